// File: rtl/hdr_pkg.sv
// Shared definitions for the HDR-DDR frame counter: FSM states, DTT decode, boundary defaults.
// Optional early-termination feature is enabled by defining FCNT_EARLY_TERM_EN.
package hdr_pkg;

    localparam int unsigned FCNT_BOUND_A_DEF = 6;
    localparam int unsigned FCNT_BOUND_B_DEF = 16;
    localparam int unsigned DTT_W            = 3;
    localparam int unsigned DTT_FRM_W        = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_LAST = 2'd2
    } fcnt_state_e;

    // Immediate transfers: DTT 0..4 carry DTT+1 frames, DTT 5..7 carry DTT-3 frames.
    function automatic logic [DTT_FRM_W-1:0] dtt_to_frames(input logic [DTT_W-1:0] dtt);
        logic [DTT_FRM_W-1:0] w_dtt;
        w_dtt = DTT_FRM_W'(dtt);
        if (dtt <= 3'd4) begin
            return w_dtt + 4'd1;
        end
        return w_dtt - 4'd3;
    endfunction

endpackage

// File: rtl/hdr_fcnt_budget.sv
// Combinational frame-budget calculation for regular and immediate commands.
// Regular budget saturates to all-ones instead of wrapping.
module hdr_fcnt_budget
    import hdr_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXTRA_FRMS = 1
) (
    input  logic             i_cmd_attr,
    input  logic [CNT_W-1:0] i_data_len,
    input  logic [DTT_W-1:0] i_dtt,
    output logic [CNT_W-1:0] o_budget_c
);

    localparam int unsigned SUM_W = CNT_W + 1;

    logic [SUM_W-1:0] w_sum;
    logic [CNT_W-1:0] w_regular;
    logic [CNT_W-1:0] w_immediate;

    // One extra bit catches the carry so overflow saturates.
    assign w_sum       = {1'b0, i_data_len} + SUM_W'(EXTRA_FRMS);
    assign w_regular   = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_immediate = CNT_W'(dtt_to_frames(i_dtt));
    assign o_budget_c  = i_cmd_attr ? w_immediate : w_regular;

endmodule

// File: rtl/hdr_frame_counter.sv
// HDR-DDR frame counter: loads a frame budget, counts word boundaries, flags the last frame.
// Define FCNT_EARLY_TERM_EN to add the i_fcnt_abort port and the o_fcnt_aborted pulse.
module hdr_frame_counter
    import hdr_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned EXTRA_FRMS = 1,
    parameter int unsigned BOUND_A    = FCNT_BOUND_A_DEF,
    parameter int unsigned BOUND_B    = FCNT_BOUND_B_DEF
) (
    input  logic             i_fcnt_clk,
    input  logic             i_fcnt_rst_n,
    input  logic             i_fcnt_load,
    input  logic             i_fcnt_en,
    input  logic             i_regf_CMD_ATTR,
    input  logic [CNT_W-1:0] i_regf_DATA_LEN,
    input  logic [2:0]       i_regf_DTT,
    input  logic             i_ccc_Direct_Broadcast_n,
    input  logic [5:0]       i_cnt_bit_count,
    input  logic             i_bitcnt_toggle,
`ifdef FCNT_EARLY_TERM_EN
    input  logic             i_fcnt_abort,
`endif
    output logic             o_fcnt_busy,
    output logic             o_cccnt_last_frame,
    output logic             o_fcnt_done,
    output logic [CNT_W-1:0] o_fcnt_remaining,
    output logic             o_fcnt_direct,
    output logic             o_fcnt_aborted
);

    fcnt_state_e      r_state;
    fcnt_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_remaining;
    logic [CNT_W-1:0] w_remaining_nxt;
    logic [CNT_W-1:0] w_budget;
    logic             r_busy;
    logic             r_last_frame;
    logic             r_done;
    logic             r_direct;
    logic             w_done_nxt;
    logic             w_direct_nxt;
    logic             w_aborted_nxt;
    logic             w_abort_req;
    logic             w_boundary;
    logic             w_tick;

    hdr_fcnt_budget #(
        .CNT_W      (CNT_W),
        .EXTRA_FRMS (EXTRA_FRMS)
    ) u_budget (
        .i_cmd_attr (i_regf_CMD_ATTR),
        .i_data_len (i_regf_DATA_LEN),
        .i_dtt      (i_regf_DTT),
        .o_budget_c (w_budget)
    );

    assign w_boundary = (i_cnt_bit_count == 6'(BOUND_A)) || (i_cnt_bit_count == 6'(BOUND_B));
    assign w_tick     = i_fcnt_en & i_bitcnt_toggle & w_boundary;

`ifdef FCNT_EARLY_TERM_EN
    assign w_abort_req = i_fcnt_abort;
`else
    assign w_abort_req = 1'b0;
`endif

    always_ff @(posedge i_fcnt_clk) begin
        if (!i_fcnt_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and next register values; abort outranks en-drop, which outranks tick.
    always_comb begin
        w_state_nxt     = r_state;
        w_remaining_nxt = r_remaining;
        w_direct_nxt    = r_direct;
        w_done_nxt      = 1'b0;
        w_aborted_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_fcnt_load) begin
                    w_remaining_nxt = w_budget;
                    w_direct_nxt    = i_ccc_Direct_Broadcast_n;
                    w_state_nxt     = (w_budget == '0) ? ST_LAST : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_abort_req) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = '0;
                    w_aborted_nxt   = 1'b1;
                end else if (!i_fcnt_en) begin
                    w_state_nxt     = ST_IDLE;
                    w_remaining_nxt = '0;
                end else if (w_tick) begin
                    if (r_remaining <= CNT_W'(1)) begin
                        w_remaining_nxt = '0;
                        w_state_nxt     = ST_LAST;
                    end else begin
                        w_remaining_nxt = r_remaining - CNT_W'(1);
                    end
                end
            end
            ST_LAST: begin
                w_remaining_nxt = '0;
                if (w_abort_req) begin
                    w_state_nxt   = ST_IDLE;
                    w_aborted_nxt = 1'b1;
                end else if (!i_fcnt_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_tick) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt     = ST_IDLE;
                w_remaining_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_fcnt_clk) begin
        if (!i_fcnt_rst_n) begin
            r_busy       <= 1'b0;
            r_last_frame <= 1'b0;
            r_done       <= 1'b0;
            r_remaining  <= '0;
            r_direct     <= 1'b0;
        end else begin
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_last_frame <= (w_state_nxt == ST_LAST);
            r_done       <= w_done_nxt;
            r_remaining  <= w_remaining_nxt;
            r_direct     <= w_direct_nxt;
        end
    end

`ifdef FCNT_EARLY_TERM_EN
    logic r_aborted;

    always_ff @(posedge i_fcnt_clk) begin
        if (!i_fcnt_rst_n) begin
            r_aborted <= 1'b0;
        end else begin
            r_aborted <= w_aborted_nxt;
        end
    end

    assign o_fcnt_aborted = r_aborted;
`else
    logic w_unused_aborted;
    assign w_unused_aborted = w_aborted_nxt;
    assign o_fcnt_aborted   = 1'b0;
`endif

    assign o_fcnt_busy        = r_busy;
    assign o_cccnt_last_frame = r_last_frame;
    assign o_fcnt_done        = r_done;
    assign o_fcnt_remaining   = r_remaining;
    assign o_fcnt_direct      = r_direct;

endmodule
